// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the 5-stage pipeline with halt drain,
// stall-cycle counter and sticky data-memory timeout flag.
module pipeline_ctrl #(
  parameter int ZERO_REG     = 0,
  parameter int DRAIN_CYCLES = 4,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  fd_rs,
  input  logic [3:0]  fd_rt,
  input  logic        fd_uses_rs,
  input  logic        fd_uses_rt,
  input  logic        fd_halt,
  input  logic        dx_memread,
  input  logic [3:0]  dx_rt,
  input  logic        br_taken,
  input  logic        imem_stall,
  input  logic        dmem_stall,
  output logic        pc_en,
  output logic        fd_en,
  output logic        dx_en,
  output logic        xm_en,
  output logic        mw_en,
  output logic        fd_flush,
  output logic        dx_flush,
  output logic        halted,
  output logic [15:0] stall_cnt,
  output logic        mem_timeout
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_t;
  state_t state, nstate;
  logic [7:0] dcnt, ndcnt, tcnt;
  logic to_flag, to_hit, lu, pc, fd, dx, xm, mw, fdf, dxf, hlt;
  assign lu = dx_memread && dx_rt != 4'(ZERO_REG) &&
              ((fd_uses_rs && fd_rs == dx_rt) || (fd_uses_rt && fd_rt == dx_rt));
  assign to_hit = tcnt == 8'(MEM_TIMEOUT);
  always_comb begin
    {pc, fd, dx, xm, mw, fdf, dxf, hlt} = 8'hF8;
    nstate = state;
    ndcnt = dcnt;
    case (state)
      RUN, MEM_WAIT: begin
        nstate = RUN;
        if (dmem_stall) begin
          {pc, fd, dx, xm, mw} = 5'b0;
          nstate = MEM_WAIT;
        end else if (br_taken) {fdf, dxf} = 2'b11;
        else if (lu) {pc, fd, dxf} = 3'b001;
        else if (imem_stall) {pc, fdf} = 2'b01;
        else if (fd_halt) begin
          {pc, fdf} = 2'b01;
          nstate = DRAIN;
          ndcnt = 8'(DRAIN_CYCLES - 1);
        end
      end
      DRAIN: begin
        if (dmem_stall) {pc, fd, dx, xm, mw} = 5'b0;
        else begin
          {pc, fdf} = 2'b01;
          nstate = dcnt == 8'd0 ? HALTED : DRAIN;
          ndcnt = dcnt == 8'd0 ? dcnt : dcnt - 8'd1;
        end
      end
      default: {pc, fd, dx, xm, mw, fdf, dxf, hlt} = 8'h01;
    endcase
  end
  // Reset forces every output to its idle value even between clock edges.
  assign {pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_flush, halted} =
    rst ? {pc, fd, dx, xm, mw, fdf, dxf, hlt} : 8'h00;
  assign mem_timeout = rst && (to_flag || to_hit);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      dcnt <= 8'd0;
      tcnt <= 8'd0;
      to_flag <= 1'b0;
      stall_cnt <= 16'd0;
    end else begin
      state <= nstate;
      dcnt <= ndcnt;
      tcnt <= !dmem_stall ? 8'd0 : (state != HALTED && tcnt != 8'hFF) ? tcnt + 8'd1 : tcnt;
      to_flag <= to_flag || to_hit;
      if ((state == RUN || state == MEM_WAIT) && !pc && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed scoreboard bench for pipeline_ctrl.
module tb_pipeline_ctrl;
  logic clk = 1'b0, rst = 1'b0;
  logic [3:0] fd_rs, fd_rt, dx_rt;
  logic fd_uses_rs, fd_uses_rt, fd_halt, dx_memread, br_taken, imem_stall, dmem_stall;
  logic pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_flush, halted, mem_timeout;
  logic [15:0] stall_cnt;
  int total = 0, bad = 0;
  typedef struct packed {logic [7:0] c; logic [15:0] s; logic t;} exp_t;
  exp_t sb[$];
  // ctl vector: {pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_flush, halted}
  localparam logic [7:0] OFF = 8'h00, RUNV = 8'hF8, LUV = 8'h3A, BRV = 8'hFE, PCF = 8'h7C, HLV = 8'h01;
  localparam logic [6:0] H = 7'h40, MR = 7'h20, BR = 7'h10, IM = 7'h08, DM = 7'h04, URS = 7'h02, URT = 7'h01;
  always #5 clk = ~clk;
  pipeline_ctrl dut (
    .clk(clk), .rst(rst), .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_uses_rs(fd_uses_rs),
    .fd_uses_rt(fd_uses_rt), .fd_halt(fd_halt), .dx_memread(dx_memread), .dx_rt(dx_rt),
    .br_taken(br_taken), .imem_stall(imem_stall), .dmem_stall(dmem_stall), .pc_en(pc_en),
    .fd_en(fd_en), .dx_en(dx_en), .xm_en(xm_en), .mw_en(mw_en), .fd_flush(fd_flush),
    .dx_flush(dx_flush), .halted(halted), .stall_cnt(stall_cnt), .mem_timeout(mem_timeout)
  );
  task automatic drive(input logic [6:0] f, input logic [3:0] rs, rt, drt);
    {fd_halt, dx_memread, br_taken, imem_stall, dmem_stall, fd_uses_rs, fd_uses_rt} = f;
    fd_rs = rs;
    fd_rt = rt;
    dx_rt = drt;
  endtask
  task automatic chk(input string tag, input logic [7:0] c, input logic [15:0] s, input logic t);
    exp_t e;
    logic [7:0] got;
    sb.push_back('{c, s, t});
    #1;
    e = sb.pop_front();
    got = {pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_flush, halted};
    total += 3;
    assert (got === e.c) else begin
      bad++;
      $error("FAIL %s ctl got=%b want=%b", tag, got, e.c);
    end
    assert (stall_cnt === e.s) else begin
      bad++;
      $error("FAIL %s stall_cnt got=%0d want=%0d", tag, stall_cnt, e.s);
    end
    assert (mem_timeout === e.t) else begin
      bad++;
      $error("FAIL %s mem_timeout got=%b want=%b", tag, mem_timeout, e.t);
    end
  endtask
  task automatic step(input string tag, input logic [6:0] f, input logic [3:0] rs, rt, drt,
                      input logic [7:0] c, input logic [15:0] s, input logic t);
    @(negedge clk);
    drive(f, rs, rt, drt);
    chk(tag, c, s, t);
  endtask
  task automatic release_rst();
    @(negedge clk);
    drive(7'h0, 4'd0, 4'd0, 4'd0);
    rst = 1'b1;
  endtask
  initial begin
    drive(7'h0, 4'd0, 4'd0, 4'd0);
    step("reset", BR | MR | URS, 4'd3, 4'd0, 4'd3, OFF, 0, 0);
    release_rst();
    step("run", 0, 0, 0, 0, RUNV, 0, 0);
    step("lu_rs", MR | URS, 4'd3, 4'd0, 4'd3, LUV, 0, 0);
    step("after_lu", 0, 4'd3, 4'd0, 4'd3, RUNV, 1, 0);
    step("lu_zero", MR | URS | URT, 4'd0, 4'd0, 4'd0, RUNV, 1, 0);
    step("lu_rt", MR | URT, 4'd1, 4'd5, 4'd5, LUV, 1, 0);
    step("rt_unused", MR, 4'd1, 4'd5, 4'd5, RUNV, 2, 0);
    step("br_over_lu", BR | MR | URS, 4'd3, 4'd0, 4'd3, BRV, 2, 0);
    step("after_br", 0, 0, 0, 0, RUNV, 2, 0);
    for (int i = 0; i < 3; i++) step("dmem_wait", DM | BR, 0, 0, 0, OFF, 16'(2 + i), 0);
    step("dmem_done_br", BR, 0, 0, 0, BRV, 5, 0);
    step("imem", IM, 0, 0, 0, PCF, 5, 0);
    step("after_imem", 0, 0, 0, 0, RUNV, 6, 0);
    step("lu_over_imem", IM | MR | URS, 4'd7, 4'd0, 4'd7, LUV, 6, 0);
    step("after_lu2", 0, 0, 0, 0, RUNV, 7, 0);
    step("br_over_halt", BR | H, 0, 0, 0, BRV, 7, 0);
    step("halt_dropped", 0, 0, 0, 0, RUNV, 7, 0);
    step("halt", H, 0, 0, 0, PCF, 7, 0);
    step("drain1", BR | MR | URS, 4'd2, 4'd0, 4'd2, PCF, 8, 0);
    step("drain_frz", DM, 0, 0, 0, OFF, 8, 0);
    step("drain2", 0, 0, 0, 0, PCF, 8, 0);
    step("drain3", IM, 0, 0, 0, PCF, 8, 0);
    step("drain4", 0, 0, 0, 0, PCF, 8, 0);
    step("halted", BR | H, 0, 0, 0, HLV, 8, 0);
    step("halted_hold", DM, 0, 0, 0, HLV, 8, 0);
    #1 rst = 1'b0;
    chk("rst_halted", OFF, 0, 0);
    release_rst();
    for (int i = 1; i <= 256; i++) step("timeout_run", DM, 0, 0, 0, OFF, 16'(i - 1), i == 256);
    step("timeout_drop", 0, 0, 0, 0, RUNV, 256, 1);
    step("timeout_sticky", 0, 0, 0, 0, RUNV, 256, 1);
    #1 rst = 1'b0;
    chk("timeout_rst", OFF, 0, 0);
    release_rst();
    step("halt_b", H, 0, 0, 0, PCF, 0, 0);
    step("drain_b", 0, 0, 0, 0, PCF, 1, 0);
    #1 rst = 1'b0;
    chk("rst_drain", OFF, 0, 0);
    release_rst();
    step("post_rst_drain", 0, 0, 0, 0, RUNV, 0, 0);
    step("memwait_b", DM, 0, 0, 0, OFF, 0, 0);
    #1 rst = 1'b0;
    chk("rst_memwait", OFF, 0, 0);
    release_rst();
    step("post_rst_mw", 0, 0, 0, 0, RUNV, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the 5-stage pipeline (F, D, X, M, W). It consumes hazard information from the F/D, D/X and X/M pipeline registers and from the memory interfaces, and drives per-stage write enables and bubble-insert flushes. It works alongside `forwarding_unit`: forwarding resolves ALU-to-ALU dependences, and this block handles everything forwarding cannot (load-use, taken branches, memory wait states, halt drain). It also maintains a stall-cycle counter and a data-memory timeout flag.

## Interface
- `ZERO_REG`, default 0: register index that is hardwired to zero and never causes a load-use hazard.
- `DRAIN_CYCLES`, default 4: cycles spent draining the pipeline after a halt is accepted.
- `MEM_TIMEOUT`, default 255: maximum consecutive `dmem_stall` cycles before `mem_timeout` is set.

Ports:
- `clk` input 1: clock. All state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `fd_rs`, `fd_rt` input 4 each: source registers of the instruction in D.
- `fd_uses_rs`, `fd_uses_rt` input 1 each: that D instruction actually reads the register.
- `fd_halt` input 1: the instruction in D is HLT.
- `dx_memread` input 1: the instruction in X is a load.
- `dx_rt` input 4: load destination register.
- `br_taken` input 1: branch/jump resolved taken in X this cycle.
- `imem_stall`, `dmem_stall` input 1 each: instruction and data memory are not ready (level).
- `pc_en`, `fd_en`, `dx_en`, `xm_en`, `mw_en` output 1 each: stage register write enables.
- `fd_flush`, `dx_flush` output 1 each: load a NOP into F/D or D/X instead of the stage's output.
- `halted` output 1: pipeline drained and stopped.
- `stall_cnt` output 16: saturating count of cycles with `pc_en`=0 while in RUN or MEM_WAIT.
- `mem_timeout` output 1: sticky error flag.

## Operation
- FSM states: RUN, MEM_WAIT, DRAIN, HALTED. Reset state is RUN.
- Load-use hazard `lu` = `dx_memread` & `dx_rt`≠`ZERO_REG` & ((`fd_uses_rs` & `fd_rs`==`dx_rt`) | (`fd_uses_rt` & `fd_rt`==`dx_rt`)).
- Outputs in RUN and MEM_WAIT are combinational from the current inputs, evaluated in the priority order below. Only the first matching rule applies. Unlisted enables are 1 and unlisted flushes are 0.
  1. `dmem_stall`: all five enables are 0 and both flushes are 0 (full freeze). Next state is MEM_WAIT.
  2. `br_taken`: `pc_en`=1 (PC loads the target), `fd_flush`=1, `dx_flush`=1.
  3. `lu`: `pc_en`=0, `fd_en`=0, `dx_flush`=1 (one bubble). X, M and W advance.
  4. `imem_stall`: `pc_en`=0, `fd_flush`=1. The remaining stages advance.
  5. `fd_halt`: `pc_en`=0, `fd_flush`=1. Next state is DRAIN and the drain counter loads `DRAIN_CYCLES`-1.
  6. Otherwise all enables are 1.
- MEM_WAIT returns to RUN on the first cycle with `dmem_stall`=0. That cycle applies rules 2-6.
- DRAIN: `pc_en`=0, `fd_flush`=1, all other enables 1. All inputs except `dmem_stall` are ignored.
  - `dmem_stall` freezes all stages and holds the drain counter.
  - When the counter reaches 0, the next state is HALTED.
- HALTED: all enables 0, flushes 0, `halted`=1. Only reset exits this state.
- Timeout counter (8 bits):
  - Increments each cycle `dmem_stall`=1 in any state other than HALTED.
  - Clears when `dmem_stall`=0.
  - Sets `mem_timeout` on the cycle the counter equals `MEM_TIMEOUT`. `mem_timeout` is cleared only by reset.
- `stall_cnt` increments on every clock edge where `pc_en`=0 and the state is RUN or MEM_WAIT. It saturates at 16'hFFFF.

## Timing
- While `rst`=0, regardless of the clock: all enables 0, flushes 0, `halted`=0, `stall_cnt`=0, `mem_timeout`=0, state RUN.
- After `rst` deasserts, outputs follow the RUN rules combinationally. There is zero latency from any hazard input to the enables and flushes.
- A load-use stall lasts exactly 1 cycle. The bubble in X clears `lu` on the next cycle without any extra state.
- A taken branch costs 2 flushed slots and 0 stall cycles.
- A halt accepted at edge N: `halted` rises after edge N+`DRAIN_CYCLES`, plus one extra cycle for each `dmem_stall` cycle during the drain.
- `br_taken` together with `fd_halt`: the branch wins and the halt is discarded (the HLT is on the flushed path).
- Reset asserted mid-DRAIN or mid-MEM_WAIT returns the block to RUN immediately.

## Test plan
- Load-use: `dx_memread`=1, `dx_rt`=3, `fd_rs`=3, `fd_uses_rs`=1 for one cycle. Required: `pc_en`=0, `fd_en`=0, `dx_flush`=1 for exactly 1 cycle, and `stall_cnt` goes 0→1. Repeat with `dx_rt`=`ZERO_REG`: no stall.
- Branch over load-use: `br_taken`=1 and `lu` true in the same cycle. Required: `pc_en`=1, `fd_flush`=1, `dx_flush`=1, and `stall_cnt` unchanged.
- Data-memory wait: `dmem_stall`=1 for 3 cycles with `br_taken`=1. Required: all enables 0 for 3 cycles, `stall_cnt`=3, then the branch flush on cycle 4.
- Halt drain: `fd_halt`=1 at cycle 10 with `DRAIN_CYCLES`=4. Required: `pc_en`=0 from cycle 10, and `halted`=1 from cycle 15 onward with all enables 0.
- Timeout: `dmem_stall` held for 256 cycles. Required: `mem_timeout`=1 starting at the 256th cycle, still 1 after `dmem_stall` drops, and 0 only after `rst`=0.
- Asynchronous reset mid-drain: `rst` driven low between clock edges during DRAIN. Required: all outputs take their reset values immediately, and after release the block is in RUN with all enables 1.
